// File: rtl/cpu_memory_pkg.sv
// cpu_memory_pkg: pipeline control bit layout and memory-stage state encoding
package cpu_memory_pkg;
   localparam int PCB_WIDTH = 3;
   localparam int PCB_WR    = 0;
   localparam int PCB_RM    = 1;
   localparam int PCB_WM    = 2;
   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
endpackage

// File: rtl/cpu_memory.sv
// cpu_memory: Moxie memory stage, one Wishbone-classic transaction per memory op
// Optional feature: define MOXIE_DMEM_ALIGN_CHECK_EN to trap misaligned accesses.
module cpu_memory
   import cpu_memory_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [PCB_WIDTH-1:0] pipeline_control_bits_i,
   input  logic [3:0]           register_write_index_i,
   input  logic [31:0]          reg_result_i,
   input  logic [31:0]          memory_address_i,
   input  logic [31:0]          mem_result_i,
   input  logic [31:0]          PC_i,
   output logic                 stall_o,
   output logic                 register_we_o,
   output logic [3:0]           register_write_index_o,
   output logic [31:0]          reg_result_o,
   output logic [31:0]          PC_o,
   output logic                 misalign_o,
   output logic [31:0]          dwb_adr_o,
   output logic [31:0]          dwb_dat_o,
   output logic [3:0]           dwb_sel_o,
   output logic                 dwb_we_o,
   output logic                 dwb_cyc_o,
   output logic                 dwb_stb_o,
   input  logic [31:0]          dwb_dat_i,
   input  logic                 dwb_ack_i
);
   state_t      state, state_nxt;
   logic        wr_lat;
   logic        is_wm, mem_op, misaligned, accept;
   logic [31:0] adr_nxt;
   assign is_wm  = pipeline_control_bits_i[PCB_WM];
   assign mem_op = pipeline_control_bits_i[PCB_RM] | is_wm;
   assign accept = (state == IDLE) && mem_op && !misaligned;
`ifdef MOXIE_DMEM_ALIGN_CHECK_EN
   logic misalign_q;
   assign misaligned = mem_op && (memory_address_i[1:0] != 2'b00);
   assign adr_nxt    = memory_address_i;
   assign misalign_o = misalign_q;
   // one-cycle pulse for a memory op refused because of its address
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) misalign_q <= 1'b0;
      else        misalign_q <= (state == IDLE) && misaligned;
`else
   assign misaligned = 1'b0;
   assign adr_nxt    = memory_address_i & ~32'h3;
   assign misalign_o = 1'b0;
`endif
   // state register
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) state <= IDLE;
      else        state <= state_nxt;
   // next state: leave IDLE on an accepted memory op, return on ack
   always_comb
      state_nxt = (state == IDLE) ? (accept ? WAIT : IDLE) : (dwb_ack_i ? IDLE : WAIT);
   // registered outputs: writeback, bus master signals, stall
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         stall_o                <= 1'b0;
         register_we_o          <= 1'b0;
         register_write_index_o <= 4'h0;
         reg_result_o           <= 32'h0;
         PC_o                   <= 32'h0;
         wr_lat                 <= 1'b0;
         dwb_adr_o              <= 32'h0;
         dwb_dat_o              <= 32'h0;
         dwb_sel_o              <= 4'h0;
         dwb_we_o               <= 1'b0;
         dwb_cyc_o              <= 1'b0;
         dwb_stb_o              <= 1'b0;
      end else if (state == IDLE) begin
         register_we_o <= !mem_op && pipeline_control_bits_i[PCB_WR];
         if (!mem_op || accept) begin
            register_write_index_o <= register_write_index_i;
            reg_result_o           <= reg_result_i;
            PC_o                   <= PC_i;
         end
         if (accept) begin
            wr_lat    <= pipeline_control_bits_i[PCB_WR];
            dwb_adr_o <= adr_nxt;
            dwb_dat_o <= is_wm ? mem_result_i : 32'h0;
            dwb_sel_o <= 4'hF;
            dwb_we_o  <= is_wm;
            dwb_cyc_o <= 1'b1;
            dwb_stb_o <= 1'b1;
            stall_o   <= 1'b1;
         end
      end else begin
         register_we_o <= 1'b0;
         if (dwb_ack_i) begin
            dwb_cyc_o     <= 1'b0;
            dwb_stb_o     <= 1'b0;
            dwb_we_o      <= 1'b0;
            stall_o       <= 1'b0;
            register_we_o <= dwb_we_o ? wr_lat : 1'b1;
            if (!dwb_we_o) reg_result_o <= dwb_dat_i;
         end
      end
endmodule

// File: tb/tb_cpu_memory.sv
// tb_cpu_memory: scoreboard bench for the memory stage
module tb_cpu_memory;
   import cpu_memory_pkg::*;
   typedef struct {logic [3:0] idx; logic [31:0] data;} wb_t;
   localparam logic [PCB_WIDTH-1:0] WR = PCB_WIDTH'(1) << PCB_WR;
   localparam logic [PCB_WIDTH-1:0] RM = PCB_WIDTH'(1) << PCB_RM;
   localparam logic [PCB_WIDTH-1:0] WM = PCB_WIDTH'(1) << PCB_WM;
   logic clk_i = 1'b0, rst_i = 1'b0;
   logic [PCB_WIDTH-1:0] pcb = '0;
   logic [3:0]  widx = '0;
   logic [31:0] rres = '0, maddr = '0, mres = '0, pc = '0, dat_i = '0;
   logic        ack = 1'b0;
   logic        stall_o, register_we_o, misalign_o, dwb_we_o, dwb_cyc_o, dwb_stb_o;
   logic [3:0]  register_write_index_o, dwb_sel_o;
   logic [31:0] reg_result_o, PC_o, dwb_adr_o, dwb_dat_o;
   int checks = 0, failures = 0, stall_cnt;
   wb_t q[$];
   wb_t e;
   cpu_memory dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .pipeline_control_bits_i(pcb), .register_write_index_i(widx),
      .reg_result_i(rres), .memory_address_i(maddr), .mem_result_i(mres), .PC_i(pc),
      .stall_o(stall_o), .register_we_o(register_we_o),
      .register_write_index_o(register_write_index_o), .reg_result_o(reg_result_o),
      .PC_o(PC_o), .misalign_o(misalign_o),
      .dwb_adr_o(dwb_adr_o), .dwb_dat_o(dwb_dat_o), .dwb_sel_o(dwb_sel_o),
      .dwb_we_o(dwb_we_o), .dwb_cyc_o(dwb_cyc_o), .dwb_stb_o(dwb_stb_o),
      .dwb_dat_i(dat_i), .dwb_ack_i(ack)
   );
   always #5 clk_i = ~clk_i;
   always @(negedge clk_i)
      if (rst_i && register_we_o) begin
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL wb_unexpected idx=%0d data=%h expected no writeback", register_write_index_o, reg_result_o);
         end else begin
            e = q.pop_front();
            if (register_write_index_o !== e.idx || reg_result_o !== e.data) begin
               failures++;
               $display("FAIL wb_value got idx=%0d data=%h expected idx=%0d data=%h", register_write_index_o, reg_result_o, e.idx, e.data);
            end
         end
      end
   task automatic step();
      @(posedge clk_i); #1;
   endtask
   task automatic test_reset();
      rst_i = 1'b0;
      step(); step();
      checks++;
      if ({stall_o, register_we_o, dwb_cyc_o, dwb_stb_o, dwb_we_o, misalign_o} !== 6'b0 || dwb_adr_o !== 32'h0 || reg_result_o !== 32'h0) begin
         failures++;
         $display("FAIL reset got ctl=%b adr=%h res=%h expected all zero", {stall_o, register_we_o, dwb_cyc_o, dwb_stb_o, dwb_we_o, misalign_o}, dwb_adr_o, reg_result_o);
      end
      rst_i = 1'b1;
      step();
   endtask
   task automatic test_alu();
      pcb = WR; widx = 4'd5; rres = 32'h1234; pc = 32'h40;
      q.push_back('{4'd5, 32'h1234});
      step();
      pcb = '0;
      checks++;
      if (register_we_o !== 1'b1 || PC_o !== 32'h40 || dwb_cyc_o !== 1'b0 || stall_o !== 1'b0) begin
         failures++;
         $display("FAIL alu got we=%b pc=%h cyc=%b stall=%b expected we=1 pc=00000040 cyc=0 stall=0", register_we_o, PC_o, dwb_cyc_o, stall_o);
      end
      step();
      checks++;
      if (register_we_o !== 1'b0) begin
         failures++;
         $display("FAIL alu_bubble got we=%b expected 0", register_we_o);
      end
   endtask
   task automatic test_load();
      pcb = RM | WR; widx = 4'd3; maddr = 32'h100; rres = 32'h0;
      q.push_back('{4'd3, 32'hDEADBEEF});
      step();
      pcb = '0;
      checks++;
      if (dwb_adr_o !== 32'h100 || dwb_we_o !== 1'b0 || dwb_cyc_o !== 1'b1 || dwb_stb_o !== 1'b1 || dwb_sel_o !== 4'hF || stall_o !== 1'b1 || register_we_o !== 1'b0) begin
         failures++;
         $display("FAIL load_bus got adr=%h we=%b cyc=%b stb=%b sel=%h stall=%b rwe=%b expected 100/0/1/1/f/1/0", dwb_adr_o, dwb_we_o, dwb_cyc_o, dwb_stb_o, dwb_sel_o, stall_o, register_we_o);
      end
      ack = 1'b1; dat_i = 32'hDEADBEEF;
      step();
      ack = 1'b0; dat_i = 32'h0;
      checks++;
      if (stall_o !== 1'b0 || dwb_cyc_o !== 1'b0 || register_we_o !== 1'b1) begin
         failures++;
         $display("FAIL load_done got stall=%b cyc=%b we=%b expected 0/0/1", stall_o, dwb_cyc_o, register_we_o);
      end
      step();
   endtask
   task automatic test_store();
      pcb = WM | WR; widx = 4'd1; maddr = 32'h1FC; mres = 32'hCAFEF00D; rres = 32'h1FC;
      q.push_back('{4'd1, 32'h1FC});
      stall_cnt = 0;
      step();
      pcb = '0; maddr = 32'h0; mres = 32'h0; rres = 32'h0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (!(dwb_cyc_o && dwb_stb_o && dwb_we_o) || dwb_adr_o !== 32'h1FC || dwb_dat_o !== 32'hCAFEF00D || register_we_o !== 1'b0) begin
            failures++;
            $display("FAIL store_hold cycle=%0d got cyc=%b stb=%b we=%b adr=%h dat=%h rwe=%b expected 1/1/1/1fc/cafef00d/0", i, dwb_cyc_o, dwb_stb_o, dwb_we_o, dwb_adr_o, dwb_dat_o, register_we_o);
         end
         if (stall_o) stall_cnt++;
         ack = (i == 3);
         step();
      end
      ack = 1'b0;
      if (stall_o) stall_cnt++;
      checks++;
      if (stall_cnt != 4 || dwb_cyc_o !== 1'b0 || register_we_o !== 1'b1) begin
         failures++;
         $display("FAIL store_done got stall_cycles=%0d cyc=%b we=%b expected 4/0/1", stall_cnt, dwb_cyc_o, register_we_o);
      end
      step();
   endtask
   task automatic test_reset_wait();
      pcb = RM | WR; widx = 4'd4; maddr = 32'h200;
      step();
      pcb = '0;
      checks++;
      if (dwb_cyc_o !== 1'b1) begin
         failures++;
         $display("FAIL rstwait_start got cyc=%b expected 1", dwb_cyc_o);
      end
      #1 rst_i = 1'b0;
      #1;
      checks++;
      if ({dwb_cyc_o, dwb_stb_o, dwb_we_o, stall_o, register_we_o} !== 5'b0) begin
         failures++;
         $display("FAIL rstwait_async got cyc/stb/we/stall/rwe=%b expected 00000", {dwb_cyc_o, dwb_stb_o, dwb_we_o, stall_o, register_we_o});
      end
      step();
      rst_i = 1'b1;
      ack = 1'b1; dat_i = 32'h99999999;
      step(); step();
      ack = 1'b0;
      checks++;
      if (register_we_o !== 1'b0 || dwb_cyc_o !== 1'b0 || stall_o !== 1'b0) begin
         failures++;
         $display("FAIL rstwait_ack got we=%b cyc=%b stall=%b expected 0/0/0", register_we_o, dwb_cyc_o, stall_o);
      end
      step();
   endtask
   task automatic test_misalign();
      pcb = RM | WR; widx = 4'd6; maddr = 32'h102;
`ifdef MOXIE_DMEM_ALIGN_CHECK_EN
      step();
      pcb = '0;
      checks++;
      if (misalign_o !== 1'b1 || dwb_cyc_o !== 1'b0 || register_we_o !== 1'b0 || stall_o !== 1'b0) begin
         failures++;
         $display("FAIL misalign_pulse got mis=%b cyc=%b we=%b stall=%b expected 1/0/0/0", misalign_o, dwb_cyc_o, register_we_o, stall_o);
      end
      step();
      checks++;
      if (misalign_o !== 1'b0) begin
         failures++;
         $display("FAIL misalign_end got mis=%b expected 0", misalign_o);
      end
`else
      q.push_back('{4'd6, 32'h11223344});
      step();
      pcb = '0;
      checks++;
      if (dwb_adr_o !== 32'h100 || dwb_cyc_o !== 1'b1 || misalign_o !== 1'b0) begin
         failures++;
         $display("FAIL misalign_adr got adr=%h cyc=%b mis=%b expected 100/1/0", dwb_adr_o, dwb_cyc_o, misalign_o);
      end
      ack = 1'b1; dat_i = 32'h11223344;
      step();
      ack = 1'b0;
      checks++;
      if (register_we_o !== 1'b1 || misalign_o !== 1'b0) begin
         failures++;
         $display("FAIL misalign_load got we=%b mis=%b expected 1/0", register_we_o, misalign_o);
      end
      step();
`endif
   endtask
   task automatic test_back_to_back();
      pcb = RM | WR; widx = 4'd7; maddr = 32'h80;
      q.push_back('{4'd7, 32'h55AA00FF});
      q.push_back('{4'd2, 32'd7});
      step();
      pcb = WR; widx = 4'd2; rres = 32'd7; maddr = 32'h0;
      ack = 1'b1; dat_i = 32'h55AA00FF;
      checks++;
      if (stall_o !== 1'b1) begin
         failures++;
         $display("FAIL b2b_stall got stall=%b expected 1", stall_o);
      end
      step();
      ack = 1'b0;
      checks++;
      if (register_write_index_o !== 4'd7 || reg_result_o !== 32'h55AA00FF || stall_o !== 1'b0) begin
         failures++;
         $display("FAIL b2b_load got idx=%0d res=%h stall=%b expected 7/55aa00ff/0", register_write_index_o, reg_result_o, stall_o);
      end
      step();
      pcb = '0;
      checks++;
      if (register_we_o !== 1'b1 || register_write_index_o !== 4'd2 || reg_result_o !== 32'd7) begin
         failures++;
         $display("FAIL b2b_add got we=%b idx=%0d res=%h expected 1/2/00000007", register_we_o, register_write_index_o, reg_result_o);
      end
      step(); step();
   endtask
   initial begin
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_reset_wait();
      test_misalign();
      test_back_to_back();
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got pending=%0d expected 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
